fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 130 +++++++++++++
 tb/tb_fetch_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/RUN/HALT sequencing of the fetch PC with
// branch redirect, stall freeze and end-of-program halt. Define FETCH_CYCLE_CNT_EN for a RUN-cycle counter.
module fetch_ctrl #(
  parameter int          AW       = 10,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] END_PC   = 32'd90
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] ir_in,
  output logic [31:0] pc,
  output logic [31:0] ir_out,
  output logic        ir_valid,
  output logic        busy,
  output logic        halted,
  output logic        err
`ifdef FETCH_CYCLE_CNT_EN
  ,
  output logic [31:0] cycle_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic [31:0]   ir_q;
  logic          valid_q;
  logic          err_q;
  logic          brOutOfRange;
  logic          atEnd;

  localparam logic [AW-1:0] ResetPcW = RESET_PC[AW-1:0];
  localparam logic [AW-1:0] EndPcW   = END_PC[AW-1:0];

  // Sequential successor wraps naturally at AW bits; a redirect takes the low bits.
  always_comb begin
    pc_d = pc_q + AW'(1);
    if (br_taken) begin
      pc_d = br_target[AW-1:0];
    end
  end

  assign brOutOfRange = |br_target[31:AW];
  assign atEnd        = (pc_q == EndPcW);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= ResetPcW;
      ir_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          pc_q    <= ResetPcW;
          if (start) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (stall) begin
            valid_q <= 1'b0;
          end else if (atEnd) begin
            // Final word still issues; any redirect this cycle is dropped.
            ir_q    <= ir_in;
            valid_q <= 1'b1;
            state_q <= HALT;
          end else if (br_taken && brOutOfRange) begin
            valid_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= HALT;
          end else begin
            ir_q    <= ir_in;
            valid_q <= 1'b1;
            pc_q    <= pc_d;
          end
        end
        HALT: begin
          valid_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            pc_q    <= ResetPcW;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_CYCLE_CNT_EN
  logic [31:0] cycleCnt_q;

  // Start only restarts the count when it actually launches a run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycleCnt_q <= '0;
    end else if (start && (state_q != RUN)) begin
      cycleCnt_q <= '0;
    end else if ((state_q == RUN) && (cycleCnt_q != 32'hFFFF_FFFF)) begin
      cycleCnt_q <= cycleCnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycleCnt_q;
`endif

  assign pc       = {{(32-AW){1'b0}}, pc_q};
  assign ir_out   = ir_q;
  assign ir_valid = valid_q;
  assign err      = err_q;
  assign busy     = (state_q == RUN);
  assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with default parameters (AW=10,
// RESET_PC=0, END_PC=90); a behavioural instruction memory returns {16'hC0DE, addr}.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic [31:0] ir_in;
  logic [31:0] pc;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        busy;
  logic        halted;
  logic        err;
`ifdef FETCH_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  int numChecks = 0;
  int numFails  = 0;

  fetch_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stall    (stall),
    .br_taken (br_taken),
    .br_target(br_target),
    .ir_in    (ir_in),
    .pc       (pc),
    .ir_out   (ir_out),
    .ir_valid (ir_valid),
    .busy     (busy),
    .halted   (halted),
    .err      (err)
`ifdef FETCH_CYCLE_CNT_EN
    ,
    .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imWord(input logic [31:0] addr);
    return {16'hC0DE, addr[15:0]};
  endfunction

  assign ir_in = imWord(pc);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic st, input logic bt, input logic [31:0] tgt);
    start     = s;
    stall     = st;
    br_taken  = bt;
    br_target = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runToPc(input logic [31:0] target);
    int n = 0;
    while (pc !== target && n < 200) begin
      tick();
      n++;
    end
    checkOutput("reachPc", pc, target);
  endtask

  initial begin
    int pulses;
    int n;

    // Reset state
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    tick();
    checkOutput("rstPc", pc, 32'd0);
    checkOutput("rstIr", ir_out, 32'd0);
    checkOutput("rstValid", 32'(ir_valid), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstHalted", 32'(halted), 32'd0);
`ifdef FETCH_CYCLE_CNT_EN
    checkOutput("rstCnt", cycle_cnt, 32'd0);
`endif

    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("idlePc", pc, 32'd0);
    checkOutput("idleBusy", 32'(busy), 32'd0);

    // Straight-line run to END_PC
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("startBusy", 32'(busy), 32'd1);
    checkOutput("startPc", pc, 32'd0);
    pulses = 0;
    n = 0;
    while (!halted && n < 300) begin
      tick();
      n++;
      if (ir_valid) begin
        checkOutput("seqIr", ir_out, imWord(32'(pulses)));
        pulses++;
      end
    end
    checkOutput("seqPulses", 32'(pulses), 32'd91);
    checkOutput("seqHalted", 32'(halted), 32'd1);
    checkOutput("seqEndPc", pc, 32'd90);
    checkOutput("seqBusy", 32'(busy), 32'd0);
    tick();
    checkOutput("haltValid", 32'(ir_valid), 32'd0);
    checkOutput("haltPc", pc, 32'd90);
    checkOutput("haltIr", ir_out, imWord(32'd90));

    // Restart from HALT, then branch at pc=12
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("restartBusy", 32'(busy), 32'd1);
    checkOutput("restartPc", pc, 32'd0);
    runToPc(32'd12);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd17);
    tick();
    checkOutput("brPc", pc, 32'd17);
    checkOutput("brIr", ir_out, imWord(32'd12));
    checkOutput("brValid", 32'(ir_valid), 32'd1);
    checkOutput("brErr", 32'(err), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checkOutput("brNextIr", ir_out, imWord(32'd17));
    checkOutput("brNextPc", pc, 32'd18);

    // Stall with branch held at pc=30
    runToPc(32'd30);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd50);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stallPc", pc, 32'd30);
      checkOutput("stallValid", 32'(ir_valid), 32'd0);
      checkOutput("stallIr", ir_out, imWord(32'd29));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd50);
    tick();
    checkOutput("unstallPc", pc, 32'd50);
    checkOutput("unstallIr", ir_out, imWord(32'd30));
    checkOutput("unstallValid", 32'(ir_valid), 32'd1);

    // Start while running has no effect
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    checkOutput("runStartPc", pc, 32'd51);
    checkOutput("runStartBusy", 32'(busy), 32'd1);

    // Address wrap at 2^AW
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd1023);
    tick();
    checkOutput("preWrapPc", pc, 32'd1023);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checkOutput("wrapPc", pc, 32'd0);
    checkOutput("wrapIr", ir_out, imWord(32'd1023));

    // Mid-run reset at pc=45, with start asserted to show reset wins
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd45);
    tick();
    checkOutput("preRstPc", pc, 32'd45);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    tick();
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstHalted", 32'(halted), 32'd0);
    checkOutput("midRstPc", pc, 32'd0);
    checkOutput("midRstValid", 32'(ir_valid), 32'd0);
    checkOutput("midRstIr", ir_out, 32'd0);
`ifdef FETCH_CYCLE_CNT_EN
    checkOutput("midRstCnt", cycle_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("postRstBusy", 32'(busy), 32'd1);

    // Out-of-range branch target
    tick();
    tick();
    checkOutput("oorPrePc", pc, 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h400);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("oorHalted", 32'(halted), 32'd1);
    checkOutput("oorErr", 32'(err), 32'd1);
    checkOutput("oorPc", pc, 32'd2);
    checkOutput("oorValid", 32'(ir_valid), 32'd0);
    checkOutput("oorBusy", 32'(busy), 32'd0);
    tick();
    checkOutput("oorErrSticky", 32'(err), 32'd1);
    checkOutput("oorPcHeld", pc, 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("oorRestartBusy", 32'(busy), 32'd1);
    checkOutput("oorRestartPc", pc, 32'd0);
    checkOutput("oorRestartErr", 32'(err), 32'd0);
`ifdef FETCH_CYCLE_CNT_EN
    checkOutput("cntAfterStart", cycle_cnt, 32'd0);
    tick();
    tick();
    tick();
    checkOutput("cntRun3", cycle_cnt, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
